alu_packet_parser: RTL and testbench

- Byte-stream packet parser between the UART RX byte buffer (an elastic pipeline stage) and the ALU datapath.
- Consumes one byte per handshake from the upstream stage's valid/yumi interface.
- Decodes a 4-byte header: opcode, reserved, length LSB, length MSB.
- Packs the payload into 32-bit little-endian operands and emits each one with first/last framing on a valid/ready interface.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_packet_parser.sv | 149 ++++++++++++++
 tb/tb_alu_packet_parser.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU packet parser: opcodes, header size, FSM states.
package alu_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned NOPS_W = 14;

    localparam logic [BYTE_W-1:0] OP_ADD = 8'hA8;
    localparam logic [BYTE_W-1:0] OP_MUL = 8'hB7;
    localparam logic [BYTE_W-1:0] OP_DIV = 8'h9A;

    localparam logic [LEN_W-1:0] HDR_LEN = 16'd4;

    typedef enum logic [2:0] {
        OPC,
        RSV,
        LLO,
        LHI,
        DATA,
        EMIT,
        DRAIN
    } state_e;

    function automatic logic is_valid_opcode(input logic [BYTE_W-1:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_packet_parser.sv
// Byte-stream parser: 4-byte header then 32-bit little-endian operands with first/last framing.
// Optional mid-packet idle abort is enabled by defining ALU_PARSER_TIMEOUT_EN.
module alu_packet_parser
    import alu_pkg::*;
#(
    parameter int unsigned timeout_p = 1000000
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [BYTE_W-1:0]   data_i,
    input  logic                valid_i,
    output logic                yumi_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [BYTE_W-1:0]   opcode_o,
    output logic [WORD_W-1:0]   operand_o,
    output logic                first_o,
    output logic                last_o,
    output logic                err_o
);

    if (timeout_p == 0) begin : g_bad_timeout
        $error("timeout_p must be nonzero");
    end

    state_e              state;
    logic [BYTE_W-1:0]   len_lo;
    logic [NOPS_W-1:0]   nops;
    logic [NOPS_W-1:0]   op_idx;
    logic [1:0]          byte_idx;
    logic [LEN_W-1:0]    drain_cnt;

    logic [LEN_W-1:0]    len_c;
    logic [LEN_W-1:0]    body_len_c;
    logic                good_c;

`ifdef ALU_PARSER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(timeout_p + 1);
    logic [TMO_W-1:0]    tmo_cnt;
`endif

    // Upstream byte is taken in every state except while an operand is waiting downstream.
    assign yumi_o = valid_i & ~reset_i & (state != EMIT);

    assign len_c      = {data_i, len_lo};
    assign body_len_c = len_c - HDR_LEN;
    // (len - 4) mod 4 equals len mod 4, so the low two bits decide alignment.
    assign good_c     = is_valid_opcode(opcode_o) && (len_c >= 16'd8) && (len_c[1:0] == 2'b00);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= OPC;
            len_lo    <= '0;
            nops      <= '0;
            op_idx    <= '0;
            byte_idx  <= '0;
            drain_cnt <= '0;
            opcode_o  <= '0;
            operand_o <= '0;
            valid_o   <= 1'b0;
            first_o   <= 1'b0;
            last_o    <= 1'b0;
            err_o     <= 1'b0;
`ifdef ALU_PARSER_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            err_o <= 1'b0;
            case (state)
                OPC: begin
                    if (yumi_o) begin
                        opcode_o <= data_i;
                        state    <= RSV;
                    end
                end
                RSV: begin
                    if (yumi_o) state <= LLO;
                end
                LLO: begin
                    if (yumi_o) begin
                        len_lo <= data_i;
                        state  <= LHI;
                    end
                end
                LHI: begin
                    if (yumi_o) begin
                        if (good_c) begin
                            nops     <= NOPS_W'(body_len_c >> 2);
                            op_idx   <= '0;
                            byte_idx <= '0;
                            state    <= DATA;
                        end else if (len_c > HDR_LEN) begin
                            err_o     <= 1'b1;
                            drain_cnt <= body_len_c;
                            state     <= DRAIN;
                        end else begin
                            err_o <= 1'b1;
                            state <= OPC;
                        end
                    end
                end
                DATA: begin
                    if (yumi_o) begin
                        operand_o[{byte_idx, 3'b000} +: BYTE_W] <= data_i;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            valid_o <= 1'b1;
                            first_o <= (op_idx == '0);
                            last_o  <= (op_idx == (nops - NOPS_W'(1)));
                            state   <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        op_idx  <= op_idx + NOPS_W'(1);
                        state   <= last_o ? OPC : DATA;
                    end
                end
                DRAIN: begin
                    if (yumi_o) begin
                        drain_cnt <= drain_cnt - LEN_W'(1);
                        if (drain_cnt == LEN_W'(1)) state <= OPC;
                    end
                end
                default: state <= OPC;
            endcase

`ifdef ALU_PARSER_TIMEOUT_EN
            // Placed after the case so an abort overrides the normal transition.
            if (yumi_o || (state == OPC)) begin
                tmo_cnt <= '0;
            end else if ((state != EMIT) && !valid_i) begin
                if (tmo_cnt == TMO_W'(timeout_p - 1)) begin
                    tmo_cnt   <= '0;
                    state     <= OPC;
                    operand_o <= '0;
                    byte_idx  <= '0;
                    err_o     <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_packet_parser.sv
// Directed self-checking bench for alu_packet_parser; timeout case runs when ALU_PARSER_TIMEOUT_EN is defined.
module tb_alu_packet_parser;

    logic        clk;
    logic        reset_i;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        yumi_o;
    logic        valid_o;
    logic        ready_i;
    logic [7:0]  opcode_o;
    logic [31:0] operand_o;
    logic        first_o;
    logic        last_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] cap_opnd[$];
    logic [7:0]  cap_opc[$];
    logic        cap_first[$];
    logic        cap_last[$];
    int          err_cnt  = 0;
    int          err_wide = 0;
    logic        err_prev = 1'b0;

    alu_packet_parser #(.timeout_p(16)) dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .yumi_o    (yumi_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .opcode_o  (opcode_o),
        .operand_o (operand_o),
        .first_o   (first_o),
        .last_o    (last_o),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: records accepted operands and error pulses.
    always @(negedge clk) begin
        if (!reset_i && valid_o && ready_i) begin
            cap_opnd.push_back(operand_o);
            cap_opc.push_back(opcode_o);
            cap_first.push_back(first_o);
            cap_last.push_back(last_o);
        end
        if (err_o) begin
            err_cnt++;
            if (err_prev) err_wide++;
        end
        err_prev = err_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        cap_opnd.delete();
        cap_opc.delete();
        cap_first.delete();
        cap_last.delete();
        err_cnt  = 0;
        err_wide = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        valid_i = 1'b1;
        data_i  = b;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (yumi_o) done = 1'b1;
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        if (!done) check("send_byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        send_byte(a);
        send_byte(b);
        send_byte(c);
        send_byte(d);
    endtask

    task automatic wait_caps(input string tag, input int n);
        for (int i = 0; i < 100 && cap_opnd.size() < n; i++) @(negedge clk);
        repeat (8) @(negedge clk);
        check(tag, 32'(cap_opnd.size()), 32'(n));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'hA8;
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_yumi", 32'(yumi_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_operand", operand_o, 32'd0);
        check("rst_opcode", 32'(opcode_o), 32'd0);
        check("rst_first_last", 32'({first_o, last_o}), 32'd0);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        reset_i = 1'b0;
        @(posedge clk);
        #1;
        clear_mon();

        // Two-operand ADD packet, downstream always ready
        send4(8'hA8, 8'h00, 8'h0C, 8'h00);
        send4(8'h01, 8'h00, 8'h00, 8'h00);
        send4(8'h02, 8'h00, 8'h00, 8'h00);
        wait_caps("p1_count", 2);
        if (cap_opnd.size() == 2) begin
            check("p1_op0", cap_opnd[0], 32'h0000_0001);
            check("p1_first0", 32'(cap_first[0]), 32'd1);
            check("p1_last0", 32'(cap_last[0]), 32'd0);
            check("p1_opc0", 32'(cap_opc[0]), 32'hA8);
            check("p1_op1", cap_opnd[1], 32'h0000_0002);
            check("p1_first1", 32'(cap_first[1]), 32'd0);
            check("p1_last1", 32'(cap_last[1]), 32'd1);
        end
        check("p1_err", 32'(err_cnt), 32'd0);

        // Same packet with a 10-cycle downstream stall on the first operand
        clear_mon();
        ready_i = 1'b0;
        send4(8'hA8, 8'h00, 8'h0C, 8'h00);
        send4(8'h01, 8'h00, 8'h00, 8'h00);
        valid_i = 1'b1;
        data_i  = 8'h02;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(valid_o), 32'd1);
            check("stall_operand", operand_o, 32'h0000_0001);
            check("stall_yumi", 32'(yumi_o), 32'd0);
        end
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        send4(8'h02, 8'h00, 8'h00, 8'h00);
        wait_caps("stall_count", 2);
        if (cap_opnd.size() == 2) begin
            check("stall_op0", cap_opnd[0], 32'h0000_0001);
            check("stall_first0", 32'(cap_first[0]), 32'd1);
            check("stall_op1", cap_opnd[1], 32'h0000_0002);
            check("stall_last1", 32'(cap_last[1]), 32'd1);
        end
        check("stall_err", 32'(err_cnt), 32'd0);

        // Bad opcode drains its 4 body bytes, then a one-operand ADD follows
        clear_mon();
        send4(8'h55, 8'h00, 8'h08, 8'h00);
        send4(8'hDE, 8'hAD, 8'hBE, 8'hEF);
        send4(8'hA8, 8'h00, 8'h08, 8'h00);
        send4(8'h11, 8'h22, 8'h33, 8'h44);
        wait_caps("badop_count", 1);
        if (cap_opnd.size() == 1) begin
            check("badop_op", cap_opnd[0], 32'h4433_2211);
            check("badop_fl", 32'({cap_first[0], cap_last[0]}), 32'd3);
            check("badop_opc", 32'(cap_opc[0]), 32'hA8);
        end
        check("badop_err", 32'(err_cnt), 32'd1);
        check("badop_err_width", 32'(err_wide), 32'd0);

        // Short length: immediate return, next byte is an opcode
        clear_mon();
        send4(8'hB7, 8'h00, 8'h03, 8'h00);
        send4(8'hB7, 8'h00, 8'h08, 8'h00);
        send4(8'h04, 8'h03, 8'h02, 8'h01);
        wait_caps("short_count", 1);
        if (cap_opnd.size() == 1) begin
            check("short_op", cap_opnd[0], 32'h0102_0304);
            check("short_opc", 32'(cap_opc[0]), 32'hB7);
        end
        check("short_err", 32'(err_cnt), 32'd1);

        // Boundary lengths: len=4 aborts at once, len=5 drains one byte
        clear_mon();
        send4(8'h9A, 8'h00, 8'h04, 8'h00);
        send4(8'h9A, 8'h00, 8'h05, 8'h00);
        send_byte(8'h77);
        send4(8'h9A, 8'h00, 8'h08, 8'h00);
        send4(8'hF0, 8'hDE, 8'hBC, 8'h9A);
        wait_caps("bound_count", 1);
        if (cap_opnd.size() == 1) begin
            check("bound_op", cap_opnd[0], 32'h9ABC_DEF0);
            check("bound_opc", 32'(cap_opc[0]), 32'h9A);
        end
        check("bound_err", 32'(err_cnt), 32'd2);

        // Reset after 6 payload bytes, then a clean packet
        clear_mon();
        send4(8'hA8, 8'h00, 8'h0C, 8'h00);
        send4(8'h01, 8'h00, 8'h00, 8'h00);
        send_byte(8'h05);
        send_byte(8'h06);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_operand", operand_o, 32'd0);
        @(posedge clk);
        #1;
        clear_mon();
        send4(8'hA8, 8'h00, 8'h08, 8'h00);
        send4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        wait_caps("midrst_count", 1);
        if (cap_opnd.size() == 1) begin
            check("midrst_op", cap_opnd[0], 32'hDDCC_BBAA);
            check("midrst_fl", 32'({cap_first[0], cap_last[0]}), 32'd3);
        end
        check("midrst_err", 32'(err_cnt), 32'd0);

`ifdef ALU_PARSER_TIMEOUT_EN
        // Idle mid-header aborts after timeout_p cycles
        clear_mon();
        send_byte(8'hA8);
        send_byte(8'h00);
        repeat (24) @(negedge clk);
        check("tmo_err", 32'(err_cnt), 32'd1);
        @(posedge clk);
        #1;
        clear_mon();
        send4(8'hA8, 8'h00, 8'h08, 8'h00);
        send4(8'h78, 8'h56, 8'h34, 8'h12);
        wait_caps("tmo_count", 1);
        if (cap_opnd.size() == 1) check("tmo_op", cap_opnd[0], 32'h1234_5678);
        check("tmo_err_after", 32'(err_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
